// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus: default widths, frame mode bit and
// the master port state encoding, reused by the arbiter and slave port.
package bus_pkg;

  localparam int unsigned AddrWidthDef = 14;
  localparam int unsigned DataWidthDef = 8;

  // Bit 0 of every frame.
  localparam logic MODE_READ  = 1'b1;
  localparam logic MODE_WRITE = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StSend,
    StRwait,
    StDone
  } port_state_e;

endpackage

// File: rtl/serial_shift_reg.sv
// Right-shifting register with parallel load. Serial data enters at the MSB
// and leaves at the LSB, so words move LSB-first in both directions.
module serial_shift_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             shift_i,
  input  logic             serial_i,
  output logic             serial_o,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q;

  // Load has priority over shift.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= data_i;
    end else if (shift_i) begin
      q_q <= {serial_i, q_q[Width-1:1]};
    end
  end

  assign serial_o = q_q[0];
  assign q_o      = q_q;

endmodule

// File: rtl/master_port.sv
// Master-side serial bus port: accepts one read/write request, wins the bus
// from the arbiter, shifts out {data, addr, mode} LSB-first and, for reads,
// collects DATA_WIDTH reply bits or gives up after TIMEOUT idle cycles.
module master_port
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidthDef,
  parameter int unsigned DATA_WIDTH = DataWidthDef,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  bus_req,
  input  logic                  bus_grant,
  output logic                  bus_out,
  output logic                  bus_valid,
  input  logic                  bus_in,
  input  logic                  bus_in_valid
);

  localparam int unsigned FrameW   = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned BitCntW  = $clog2(FrameW);
  localparam int unsigned RxCntW   = $clog2(DATA_WIDTH + 1);
  localparam int unsigned IdleCntW = $clog2(TIMEOUT + 1);

  // Index of the final frame bit; reads stop after the address.
  localparam logic [BitCntW-1:0]  LastWrBit = BitCntW'(FrameW - 1);
  localparam logic [BitCntW-1:0]  LastRdBit = BitCntW'(ADDR_WIDTH);
  localparam logic [RxCntW-1:0]   LastRxBit = RxCntW'(DATA_WIDTH - 1);
  localparam logic [IdleCntW-1:0] IdleLimit = IdleCntW'(TIMEOUT - 1);

  port_state_e           state_q;
  logic                  rd_q;
  logic [BitCntW-1:0]    bit_cnt_q;
  logic [RxCntW-1:0]     rx_cnt_q;
  logic [IdleCntW-1:0]   idle_cnt_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  bus_req_q;
  logic                  bus_out_q;
  logic                  bus_valid_q;

  logic                  accept;
  logic                  tx_last;
  logic                  tx_shift;
  logic                  rx_shift;
  logic [FrameW-1:0]     tx_frame;
  logic                  tx_sout;
  logic [FrameW-1:0]     unused_tx_q;
  logic [DATA_WIDTH-1:0] rx_q;
  logic                  unused_rx_sout;

  assign accept   = (state_q == StIdle) && enable;
  assign tx_last  = rd_q ? (bit_cnt_q == LastRdBit) : (bit_cnt_q == LastWrBit);
  // The register always holds the next bit to put on the line.
  assign tx_shift = ((state_q == StReq) && bus_grant) || ((state_q == StSend) && !tx_last);
  assign rx_shift = (state_q == StRwait) && bus_in_valid;
  assign tx_frame = {data_in, addr_in, (read_en ? MODE_READ : MODE_WRITE)};

  serial_shift_reg #(
    .Width (FrameW)
  ) u_tx_shift (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (accept),
    .data_i   (tx_frame),
    .shift_i  (tx_shift),
    .serial_i (1'b0),
    .serial_o (tx_sout),
    .q_o      (unused_tx_q)
  );

  serial_shift_reg #(
    .Width (DATA_WIDTH)
  ) u_rx_shift (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (1'b0),
    .data_i   ('0),
    .shift_i  (rx_shift),
    .serial_i (bus_in),
    .serial_o (unused_rx_sout),
    .q_o      (rx_q)
  );

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rd_q        <= 1'b0;
      bit_cnt_q   <= '0;
      rx_cnt_q    <= '0;
      idle_cnt_q  <= '0;
      data_out_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_out_q   <= 1'b0;
      bus_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            rd_q      <= read_en;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            bus_req_q <= 1'b1;
            state_q   <= StReq;
          end
        end
        StReq: begin
          if (bus_grant) begin
            bus_valid_q <= 1'b1;
            bus_out_q   <= tx_sout;
            bit_cnt_q   <= '0;
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (tx_last) begin
            bus_valid_q <= 1'b0;
            bus_out_q   <= 1'b0;
            if (rd_q) begin
              rx_cnt_q   <= '0;
              idle_cnt_q <= '0;
              state_q    <= StRwait;
            end else begin
              done_q    <= 1'b1;
              bus_req_q <= 1'b0;
              state_q   <= StDone;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
            bus_out_q <= tx_sout;
          end
        end
        StRwait: begin
          if (bus_in_valid) begin
            idle_cnt_q <= '0;
            if (rx_cnt_q == LastRxBit) begin
              // Capture the word including the bit arriving this cycle.
              data_out_q <= {bus_in, rx_q[DATA_WIDTH-1:1]};
              done_q     <= 1'b1;
              bus_req_q  <= 1'b0;
              state_q    <= StDone;
            end else begin
              rx_cnt_q <= rx_cnt_q + RxCntW'(1);
            end
          end else if (idle_cnt_q == IdleLimit) begin
            err_q     <= 1'b1;
            done_q    <= 1'b1;
            bus_req_q <= 1'b0;
            state_q   <= StDone;
          end else begin
            idle_cnt_q <= idle_cnt_q + IdleCntW'(1);
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign bus_req   = bus_req_q;
  assign bus_out   = bus_out_q;
  assign bus_valid = bus_valid_q;

endmodule

// File: tb/tb_master_port.sv
// Bench for master_port: a table of directed transactions, hand-written reset
// sequences and randomized transactions, all judged against timing and frame
// contents computed arithmetically from the bus protocol rules.
module tb_master_port;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          read_en;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          done;
  logic          err;
  logic          bus_req;
  logic          bus_grant;
  logic          bus_out;
  logic          bus_valid;
  logic          bus_in;
  logic          bus_in_valid;

  int            tests = 0;
  int            failed = 0;
  logic [DW-1:0] mdl_data;

  always #5 clk = ~clk;

  master_port #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .read_en      (read_en),
    .addr_in      (addr_in),
    .data_in      (data_in),
    .data_out     (data_out),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .bus_req      (bus_req),
    .bus_grant    (bus_grant),
    .bus_out      (bus_out),
    .bus_valid    (bus_valid),
    .bus_in       (bus_in),
    .bus_in_valid (bus_in_valid)
  );

  typedef struct {
    bit            rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            gdly;
    int            gap;
    bit            reply;
    logic [DW-1:0] rdata;
    int            reen;
    int            exp_done;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle of the done pulse, counting the enable-sampling cycle as 0.
  function automatic int model_done(bit rd, int gdly, int gap, bit reply);
    int flen;
    int rstart;
    flen   = rd ? 1 + AW : 1 + AW + DW;
    rstart = 2 + gdly + flen;
    if (!rd) return rstart;
    if (!reply) return rstart + TO;
    return rstart + (DW - 1) * (gap + 1) + 1;
  endfunction

  // One request from enable to idle; inputs change and outputs are sampled on
  // the falling edge, so cycle c's inputs are the ones seen at its closing edge.
  task automatic run_txn(input string tag, input bit rd, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int gdly, input int gap, input bit reply,
                         input logic [DW-1:0] rdata, input int reen, input bit noise,
                         input int exp_done);
    int            flen;
    int            send_start;
    int            rstart;
    int            first_valid;
    int            nvalid;
    int            done_cyc;
    int            ndone;
    int            viol;
    int            k;
    logic [31:0]   cap;
    logic [31:0]   exp_fr;
    logic          exp_err;
    logic          err_at_done;
    logic [DW-1:0] exp_dout;
    logic [DW-1:0] dout_at_done;

    flen       = rd ? 1 + AW : 1 + AW + DW;
    send_start = 2 + gdly;
    rstart     = send_start + flen;
    exp_fr     = 32'({d, a, rd});
    if (rd) exp_fr = exp_fr & ((32'd1 << flen) - 32'd1);
    exp_err  = rd && !reply;
    exp_dout = (rd && reply) ? rdata : mdl_data;

    first_valid  = -1;
    nvalid       = 0;
    done_cyc     = -1;
    ndone        = 0;
    viol         = 0;
    cap          = '0;
    err_at_done  = 1'b0;
    dout_at_done = '0;

    for (int c = 0; c <= exp_done + 2; c++) begin
      @(negedge clk);
      if (bus_valid) begin
        if (first_valid < 0) first_valid = c;
        if (nvalid < 32) cap[nvalid] = bus_out;
        nvalid++;
      end else if (bus_out !== 1'b0) begin
        viol++;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc     = c;
          err_at_done  = err;
          dout_at_done = data_out;
        end
      end
      if (busy !== (c >= 1 && c <= exp_done)) viol++;
      if (bus_req !== (c >= 1 && c < exp_done)) viol++;

      enable = (c == 0) || (c == reen);
      if (c == 0) begin
        read_en = rd;
        addr_in = a;
        data_in = d;
      end else if (c == reen) begin
        read_en = ~rd;
        addr_in = AW'(9193);
        data_in = ~d;
      end else begin
        read_en = 1'($urandom);
        addr_in = AW'($urandom);
        data_in = DW'($urandom);
      end
      bus_grant    = (c >= 1 + gdly) && (c < exp_done);
      bus_in_valid = 1'b0;
      bus_in       = 1'b0;
      if (c >= rstart) begin
        if (reply && ((c - rstart) % (gap + 1)) == 0 && ((c - rstart) / (gap + 1)) < DW) begin
          k            = (c - rstart) / (gap + 1);
          bus_in_valid = 1'b1;
          bus_in       = rdata[k];
        end
      end else if (noise) begin
        bus_in_valid = 1'($urandom);
        bus_in       = 1'($urandom);
      end
    end
    enable       = 1'b0;
    bus_grant    = 1'b0;
    bus_in_valid = 1'b0;

    check({tag, " frame_start"}, first_valid, send_start);
    check({tag, " frame_len"}, nvalid, flen);
    check({tag, " frame_bits"}, cap, exp_fr);
    check({tag, " done_cycle"}, done_cyc, exp_done);
    check({tag, " done_pulses"}, ndone, 1);
    check({tag, " err"}, 32'(err_at_done), 32'(exp_err));
    check({tag, " data_out"}, 32'(dout_at_done), 32'(exp_dout));
    check({tag, " handshake"}, viol, 0);
    check({tag, " err_hold"}, 32'(err), 32'(exp_err));
    check({tag, " data_hold"}, 32'(data_out), 32'(exp_dout));
    mdl_data = exp_dout;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " err"}, 32'(err), 0);
    check({tag, " bus_req"}, 32'(bus_req), 0);
    check({tag, " bus_out"}, 32'(bus_out), 0);
    check({tag, " bus_valid"}, 32'(bus_valid), 0);
    check({tag, " data_out"}, 32'(data_out), 0);
  endtask

  initial begin
    int ndone;
    bit rd;
    bit reply;
    int gdly;
    int gap;
    int reen;

    vecs[0] = '{rd: 0, addr: 14'd1001, data: 8'd101, gdly: 0, gap: 0, reply: 0, rdata: 8'h00,
                reen: -1, exp_done: 25};
    vecs[1] = '{rd: 1, addr: 14'd5097, data: 8'h00, gdly: 0, gap: 0, reply: 1, rdata: 8'h65,
                reen: -1, exp_done: 25};
    vecs[2] = '{rd: 1, addr: 14'd77, data: 8'h00, gdly: 10, gap: 3, reply: 1, rdata: 8'hB4,
                reen: -1, exp_done: 56};
    vecs[3] = '{rd: 1, addr: 14'd300, data: 8'h00, gdly: 0, gap: 0, reply: 0, rdata: 8'h00,
                reen: -1, exp_done: 81};
    vecs[4] = '{rd: 0, addr: 14'd1234, data: 8'h5A, gdly: 0, gap: 0, reply: 0, rdata: 8'h00,
                reen: 8, exp_done: 25};
    vecs[5] = '{rd: 1, addr: 14'd16383, data: 8'h00, gdly: 2, gap: 1, reply: 1, rdata: 8'h81,
                reen: -1, exp_done: 34};
    vecs[6] = '{rd: 1, addr: 14'd42, data: 8'h00, gdly: 0, gap: 63, reply: 1, rdata: 8'h3C,
                reen: -1, exp_done: 466};

    reset        = 1'b1;
    enable       = 1'b0;
    read_en      = 1'b0;
    addr_in      = '0;
    data_in      = '0;
    bus_grant    = 1'b0;
    bus_in       = 1'b0;
    bus_in_valid = 1'b0;
    mdl_data     = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].gdly,
              vecs[i].gap, vecs[i].reply, vecs[i].rdata, vecs[i].reen, 1'b0, vecs[i].exp_done);
    end

    // Reset in the middle of a write frame: outputs clear, no done follows.
    @(negedge clk);
    enable  = 1'b1;
    read_en = 1'b0;
    addr_in = 14'd2222;
    data_in = 8'hC3;
    @(negedge clk);
    enable    = 1'b0;
    bus_grant = 1'b1;
    repeat (8) @(negedge clk);
    check("midsend bus_valid", 32'(bus_valid), 1);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midsend_reset");
    mdl_data  = '0;
    reset     = 1'b0;
    bus_grant = 1'b0;
    ndone     = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midsend no_done", ndone, 0);
    run_txn("after_reset", 1'b0, 14'd5098, 8'd102, 0, 0, 1'b0, 8'h00, -1, 1'b0, 25);

    // Enable together with reset: the request is dropped.
    @(negedge clk);
    reset   = 1'b1;
    enable  = 1'b1;
    read_en = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check("en_with_reset busy", 32'(busy), 0);
    check("en_with_reset bus_req", 32'(bus_req), 0);

    for (int i = 0; i < 16; i++) begin
      rd    = 1'($urandom);
      reply = ($urandom % 4) != 0;
      gdly  = int'($urandom_range(0, 5));
      gap   = int'($urandom_range(0, 3));
      reen  = ($urandom % 2) != 0 ? int'($urandom_range(3, 12)) : -1;
      run_txn($sformatf("rnd%0d", i), rd, AW'($urandom), DW'($urandom), gdly, gap, reply,
              DW'($urandom), reen, 1'b1, model_done(rd, gdly, gap, reply));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
